fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
//  Shares the single write port of the async FIFO write side among NUM_REQ requesters in w_clk domain.
//  Round-robin grant with bounded bursts; sequences FIFO flush (flush+wr_enable, one cycle) between bursts.
//  Sits directly in front of the FIFO write-pointer logic; consumes its registered full flag.
// PARAMETERS
//  DATA_WIDTH  8   width of one write beat
//  NUM_REQ     4   number of requesters (>=2)
//  MAX_BURST   4   max beats per grant (>=1)
//  CNT_WIDTH   16  width of statistics counter (WR_ARB_STATS_EN only)
// PORTS
//  w_clk       in   1                     write-domain clock
//  wreset      in   1                     synchronous, active-high reset
//  req_valid   in   NUM_REQ               per-requester beat valid
//  req_data    in   NUM_REQ*DATA_WIDTH    per-requester beat data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_last    in   NUM_REQ               beat is last of requester burst
//  req_ready   out  NUM_REQ               beat accepted when req_valid[i]&req_ready[i]
//  flush_req   in   1                     single-cycle flush request pulse
//  flush_done  out  1                     one-cycle pulse, flush issued to FIFO
//  full        in   1                     FIFO full flag (registered, write side)
//  wr_enable   out  1                     FIFO write request
//  flush       out  1                     FIFO flush, only ever asserted together with wr_enable
//  wr_data     out  DATA_WIDTH            data of granted requester
//  grant_id    out  $clog2(NUM_REQ)       current/last granted requester
//  busy        out  1                     state != IDLE
//  stat_beats  out  CNT_WIDTH             accepted-beat count (WR_ARB_STATS_EN only)
// BEHAVIOUR
//  Reset (sync, wreset=1): state IDLE, flush_pend=0, grant_id=NUM_REQ-1 (req 0 wins first), beat_cnt=0;
//   all outputs 0. Reset mid-burst abandons burst; no beat accepted in reset cycle.
//  flush_pend: set by flush_req, cleared in FLUSH; flush_req while pending is absorbed (one flush).
//  FSM IDLE/GRANT/FLUSH:
//   IDLE: flush_pend (or flush_req) -> FLUSH (flush beats requests). Else any req_valid -> GRANT,
//    grant_id <= first valid after old grant_id (rr, wrap NUM_REQ-1 -> 0), beat_cnt <= 0. No beat in IDLE.
//   GRANT: req_ready[grant_id] = ~full, others 0; wr_enable = req_valid[g] & ~full; wr_data = req_data[g].
//    Beat = wr_enable. beat_cnt++ per beat. Exit to IDLE after beat with req_last, after beat MAX_BURST,
//    or in any cycle req_valid[g]=0. flush_pend in GRANT: current-cycle beat completes, then -> FLUSH.
//   FLUSH: exactly 1 cycle: wr_enable=1, flush=1, flush_done=1, req_ready=0, flush_pend<=0; -> IDLE.
//  full=1 in GRANT: stall (no beat, no count), grant held, no timeout.
//  Latency: req_valid in IDLE -> first beat next cycle earliest; back-to-back bursts have 1 IDLE bubble.
//  wr_enable/req_ready/wr_data combinational from state, full, req_valid; state, grant_id, counters registered.
//  Widths: beat_cnt $clog2(MAX_BURST+1) bits; grant_id increments modulo NUM_REQ, not power-of-2 wrap.
// CONFIGURATION
//  WR_ARB_STATS_EN defined: stat_beats counts beats (not flushes), saturates at all-ones, cleared by
//   wreset and by FLUSH cycle. Not defined: stat_beats port and counter absent; behaviour otherwise identical.
// STRUCTURE
//  fifo_arb_pkg: arb_state_e enum {IDLE,GRANT,FLUSH}; rr_next() helper function.
//  Sub-module fifo_rr_pick: combinational rr selector (req_valid, last grant -> winner, any_valid).
//  Top holds FSM, beat counter, flush_pend, data mux, optional stats counter.
// TESTING
//  Reset, all req_valid=4'b1111 each with 4-beat bursts -> grant order 0,1,2,3,0; 4 beats each, 1-cycle gap.
//  req 2 sends 6 beats, no req_last, MAX_BURST=4 -> 4 beats, IDLE, re-granted to 2 if alone, 2 beats.
//  full=1 for 3 cycles mid-burst -> req_ready=0, wr_enable=0, beat_cnt/stat_beats frozen, burst resumes.
//  flush_req during beat 2 of burst -> beat 2 accepted, next cycle wr_enable=flush=flush_done=1, then IDLE.
//  flush_req twice while pending + wreset pulsed mid-GRANT -> single flush; reset returns IDLE, outputs 0.
//  WR_ARB_STATS_EN: 300 beats with CNT_WIDTH=8 -> stat_beats=255; after flush -> 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Holds the arbiter FSM encoding and the round-robin step function.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        FLUSH = 2'd2
    } arb_state_e;

    // Next index after cur, wrapping at n rather than at a power of two.
    function automatic int rr_next(input int cur, input int n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin selector: first valid requester after
// the last grant, searching upward and wrapping to 0.
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDW-1:0]     last_grant,
    output logic [IDW-1:0]     winner,
    output logic               any_valid
);

    // Walk the ring once starting just after the previous owner.
    always_comb begin
        int idx;
        idx       = int'(last_grant);
        winner    = last_grant;
        any_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = rr_next(idx, NUM_REQ);
            if (!any_valid && req_valid[IDW'(idx)]) begin
                winner    = IDW'(idx);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter with bounded bursts and flush sequencing.
// Optional beat statistics counter enabled by WR_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
`ifdef WR_ARB_STATS_EN
    ,
    parameter int CNT_WIDTH  = 16
`endif
) (
    input  logic                          w_clk,
    input  logic                          wreset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          flush_req,
    output logic                          flush_done,
    input  logic                          full,
    output logic                          wr_enable,
    output logic                          flush,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
`ifdef WR_ARB_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]          stat_beats
`endif
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int BCW = $clog2(MAX_BURST + 1);

    arb_state_e      state_q, state_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic [BCW-1:0]  cnt_q, cnt_d;
    logic            pend_q, pend_d;

    logic [IDW-1:0]        winner;
    logic                  any_valid;
    logic                  g_valid;
    logic                  g_last;
    logic [DATA_WIDTH-1:0] g_data;
    logic                  flush_any;
    logic                  beat;
    logic                  last_beat;

    fifo_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req_valid  (req_valid),
        .last_grant (grant_q),
        .winner     (winner),
        .any_valid  (any_valid)
    );

    assign g_valid   = req_valid[grant_q];
    assign g_last    = req_last[grant_q];
    assign g_data    = req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    assign flush_any = pend_q | flush_req;
    assign beat      = (state_q == GRANT) & g_valid & ~full & ~wreset;
    assign last_beat = beat & (g_last | (cnt_q == BCW'(MAX_BURST - 1)));
    assign grant_id  = grant_q;
    assign busy      = (state_q != IDLE) & ~wreset;

    // Register FSM state, grant owner, burst beat count and pending flush.
    always_ff @(posedge w_clk) begin
        if (wreset) begin
            state_q <= IDLE;
            grant_q <= IDW'(NUM_REQ - 1);
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // Next-state decode and the combinational write-port outputs.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        pend_d     = flush_any;
        req_ready  = '0;
        wr_enable  = 1'b0;
        flush      = 1'b0;
        flush_done = 1'b0;
        wr_data    = '0;
        unique case (state_q)
            IDLE: begin
                if (flush_any) begin
                    state_d = FLUSH;
                end else if (any_valid) begin
                    state_d = GRANT;
                    grant_d = winner;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                req_ready[grant_q] = ~full;
                wr_enable          = g_valid & ~full;
                wr_data            = g_data;
                if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (flush_any) begin
                    state_d = FLUSH;
                end else if (!g_valid || last_beat) begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                wr_enable  = 1'b1;
                flush      = 1'b1;
                flush_done = 1'b1;
                pend_d     = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (wreset) begin
            req_ready  = '0;
            wr_enable  = 1'b0;
            flush      = 1'b0;
            flush_done = 1'b0;
            wr_data    = '0;
        end
    end

`ifdef WR_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] stat_q;

    // Saturating accepted-beat counter, cleared by reset and by a flush.
    always_ff @(posedge w_clk) begin
        if (wreset) begin
            stat_q <= '0;
        end else if (state_q == FLUSH) begin
            stat_q <= '0;
        end else if (beat && (stat_q != '1)) begin
            stat_q <= stat_q + 1'b1;
        end
    end

    assign stat_beats = stat_q;
`endif

endmodule
